seg_scan: RTL and testbench

Four-digit, time-multiplexed seven-segment display driver sitting directly downstream of the clock divider. It consumes the divider's free-running segclk square wave as a scan-rate reference and cycles the anodes of a common-anode 4-digit display. Values are double-buffered so a frame never shows a mix of old and new digits. A guard interval with all anodes off is inserted at every digit change to suppress ghosting.

---
 rtl/seg_pkg.sv | 34 +++
 rtl/seg_decode.sv | 12 +
 rtl/seg_scan.sv | 162 ++++++++++++++++
 tb/tb_seg_scan.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  // Entry n is the pattern for hex digit n; the concatenation lists F first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Bit i is set when digit i and every digit above it are zero.
  function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(
    input logic [4*NUM_DIGITS-1:0] v
  );
    logic run;
    lead_zero_mask = '0;
    run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run = run & (v[4*i +: 4] == 4'h0);
      lead_zero_mask[i] = run;
    end
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Hex nibble to active-low seven-segment pattern; pure table lookup.
// Combinational, no state.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scanner, stepped by synchronized segclk rising edges.
// Outputs are registered; loads are staged and only reach the display at a frame wrap.
module seg_scan
  import seg_pkg::*;
#(
  parameter int GUARD = 64,
  parameter bit LZS   = 1'b0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        segclk,
  input  logic [15:0] value,
  input  logic [3:0]  blank,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam logic [7:0] GUARD_LOAD = 8'(GUARD - 1);

  logic [1:0]  sync_q;
  logic        edge_q;
  logic        step;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [1:0]  idx, idx_nxt;
  logic        enter_guard;
  logic        drive_start;
  logic        wrap;

  logic [15:0] stg_val, disp_val;
  logic [3:0]  stg_blank, disp_blank;
  logic [3:0]  stg_dp, disp_dp;
  logic        pending;

  logic [3:0]  digit;
  logic [6:0]  seg_dec;
  logic [3:0]  lead_zero;
  logic        dark;

  // segclk is asynchronous: two flops, then a third for edge detection.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync_q <= 2'b00;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], segclk};
      edge_q <= sync_q[1];
    end
  end

  assign step = sync_q[1] & ~edge_q;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    enter_guard = 1'b0;
    case (state)
      ST_IDLE, ST_DRIVE: begin
        if (step) begin
          state_nxt   = ST_GUARD;
          idx_nxt     = idx + 2'd1;
          cnt_nxt     = GUARD_LOAD;
          enter_guard = 1'b1;
        end
      end
      ST_GUARD: begin
        // Steps landing here are dropped on purpose, not queued.
        if (cnt == 8'd0) begin
          state_nxt = ST_DRIVE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign drive_start = (state == ST_GUARD) && (cnt == 8'd0);
  assign wrap        = enter_guard && (idx_nxt == 2'd0);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
      idx   <= 2'd3;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      stg_val    <= 16'h0;
      stg_blank  <= 4'h0;
      stg_dp     <= 4'h0;
      disp_val   <= 16'h0;
      disp_blank <= 4'h0;
      disp_dp    <= 4'h0;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        stg_val   <= value;
        stg_blank <= blank;
        stg_dp    <= dp_in;
      end
      if (wrap) begin
        // A load coinciding with the wrap bypasses staging.
        if (load) begin
          disp_val   <= value;
          disp_blank <= blank;
          disp_dp    <= dp_in;
        end else if (pending) begin
          disp_val   <= stg_val;
          disp_blank <= stg_blank;
          disp_dp    <= stg_dp;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  assign digit     = disp_val[{idx, 2'b00} +: 4];
  assign lead_zero = lead_zero_mask(disp_val);
  assign dark      = disp_blank[idx] | (LZS & (idx != 2'd0) & lead_zero[idx]);

  seg_decode u_decode (
    .nibble (digit),
    .seg    (seg_dec)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      an    <= 4'hF;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
      frame <= 1'b0;
    end else begin
      frame <= drive_start & (idx == 2'd0);
      if (drive_start) begin
        an  <= ~(4'b0001 << idx);
        seg <= dark ? SEG_BLANK : seg_dec;
        // Only the blank mask hides the point; leading-zero suppression keeps it.
        dp  <= disp_blank[idx] | ~disp_dp[idx];
      end else if (enter_guard) begin
        an  <= 4'hF;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: two instances (GUARD=4/LZS=0 and GUARD=200/LZS=1) against a frame-level model.
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        clr;
  logic        segclk0, segclk1;
  logic [15:0] value;
  logic [3:0]  blank, dp_in;
  logic        load0, load1;
  logic [3:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1, frame0, frame1;

  int checks = 0;
  int failures = 0;
  int sel = 0;

  logic [3:0] an_x;
  logic [6:0] seg_x;
  logic       dp_x, frame_x;

  // Model state per instance: shown frame, staged frame, pending flag, index.
  logic [15:0] m_val [2];
  logic [15:0] s_val [2];
  logic [3:0]  m_blk [2];
  logic [3:0]  s_blk [2];
  logic [3:0]  m_dpm [2];
  logic [3:0]  s_dpm [2];
  bit          m_pend [2];
  int          m_idx [2];

  seg_scan #(.GUARD(4), .LZS(1'b0)) u0 (
    .clk(clk), .clr(clr), .segclk(segclk0), .value(value), .blank(blank),
    .dp_in(dp_in), .load(load0), .an(an0), .seg(seg0), .dp(dp0), .frame(frame0)
  );

  seg_scan #(.GUARD(200), .LZS(1'b1)) u1 (
    .clk(clk), .clr(clr), .segclk(segclk1), .value(value), .blank(blank),
    .dp_in(dp_in), .load(load1), .an(an1), .seg(seg1), .dp(dp1), .frame(frame1)
  );

  always #5 clk = ~clk;

  assign an_x    = (sel == 1) ? an1 : an0;
  assign seg_x   = (sel == 1) ? seg1 : seg0;
  assign dp_x    = (sel == 1) ? dp1 : dp0;
  assign frame_x = (sel == 1) ? frame1 : frame0;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: ref_seg = 7'b1000000;
      4'h1: ref_seg = 7'b1111001;
      4'h2: ref_seg = 7'b0100100;
      4'h3: ref_seg = 7'b0110000;
      4'h4: ref_seg = 7'b0011001;
      4'h5: ref_seg = 7'b0010010;
      4'h6: ref_seg = 7'b0000010;
      4'h7: ref_seg = 7'b1111000;
      4'h8: ref_seg = 7'b0000000;
      4'h9: ref_seg = 7'b0010000;
      4'hA: ref_seg = 7'b0001000;
      4'hB: ref_seg = 7'b0000011;
      4'hC: ref_seg = 7'b1000110;
      4'hD: ref_seg = 7'b0100001;
      4'hE: ref_seg = 7'b0000110;
      default: ref_seg = 7'b0001110;
    endcase
  endfunction

  function automatic int guard_len(input int s);
    guard_len = (s == 1) ? 200 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic reset_model();
    for (int s = 0; s < 2; s++) begin
      m_val[s] = 16'h0; s_val[s] = 16'h0;
      m_blk[s] = 4'h0;  s_blk[s] = 4'h0;
      m_dpm[s] = 4'h0;  s_dpm[s] = 4'h0;
      m_pend[s] = 1'b0;
      m_idx[s] = 3;
    end
  endtask

  task automatic set_segclk(input int s, input logic v);
    if (s == 0) segclk0 = v; else segclk1 = v;
  endtask

  task automatic set_load(input int s, input logic v);
    if (s == 0) load0 = v; else load1 = v;
  endtask

  task automatic do_load(input int s, input logic [15:0] v, input logic [3:0] b, input logic [3:0] d);
    @(posedge clk); #1;
    value = v; blank = b; dp_in = d;
    set_load(s, 1'b1);
    @(posedge clk); #1;
    set_load(s, 1'b0);
    s_val[s] = v; s_blk[s] = b; s_dpm[s] = d;
    m_pend[s] = 1'b1;
  endtask

  task automatic check_drive(input int s, input string tag);
    int         ei;
    logic [3:0] ea;
    logic [3:0] nib;
    logic       dk;
    logic [6:0] es;
    logic       ed;
    ei = m_idx[s];
    ea = 4'hF;
    ea[ei] = 1'b0;
    nib = m_val[s][4*ei +: 4];
    dk = m_blk[s][ei] || (s == 1 && ei != 0 && (m_val[s] >> (4*ei)) == 16'h0);
    es = dk ? 7'h7F : ref_seg(nib);
    ed = m_blk[s][ei] ? 1'b1 : ~m_dpm[s][ei];
    chk({tag, "_an"}, 32'(an_x), 32'(ea));
    chk({tag, "_seg"}, 32'(seg_x), 32'(es));
    chk({tag, "_dp"}, 32'(dp_x), 32'(ed));
    chk({tag, "_frame"}, 32'(frame_x), 32'(ei == 0));
    @(posedge clk); #1;
    chk({tag, "_frame_end"}, 32'(frame_x), 32'd0);
    chk({tag, "_an_hold"}, 32'(an_x), 32'(ea));
  endtask

  // One scan step; optional load in the step cycle and optional second rise inside the guard.
  task automatic do_step(input int s, input bit ld, input logic [15:0] v,
                         input logic [3:0] b, input logic [3:0] d, input bit dbl);
    int  gcnt;
    int  k;
    bit  done;
    sel = s;
    @(posedge clk); #1;
    set_segclk(s, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (ld) begin
      value = v; blank = b; dp_in = d;
      set_load(s, 1'b1);
    end
    @(posedge clk); #1;
    set_load(s, 1'b0);
    set_segclk(s, 1'b0);
    m_idx[s] = (m_idx[s] + 1) % 4;
    if (ld) begin
      if (m_idx[s] == 0) begin
        m_val[s] = v; m_blk[s] = b; m_dpm[s] = d;
        m_pend[s] = 1'b0;
      end else begin
        s_val[s] = v; s_blk[s] = b; s_dpm[s] = d;
        m_pend[s] = 1'b1;
      end
    end else if (m_idx[s] == 0 && m_pend[s]) begin
      m_val[s] = s_val[s]; m_blk[s] = s_blk[s]; m_dpm[s] = s_dpm[s];
      m_pend[s] = 1'b0;
    end
    chk("step_latency_an_off", 32'(an_x), 32'hF);
    gcnt = 1;
    k = 0;
    done = 1'b0;
    while (!done && k < 600) begin
      @(posedge clk); #1;
      k++;
      if (dbl && k == 10) set_segclk(s, 1'b1);
      if (dbl && k == 16) set_segclk(s, 1'b0);
      if (an_x == 4'hF) gcnt++;
      else done = 1'b1;
    end
    chk("guard_len", 32'(gcnt), 32'(guard_len(s)));
    check_drive(s, "drive");
  endtask

  initial begin
    logic [15:0] rv;
    logic [3:0]  rb, rd;
    int          mode;

    clr = 1'b0; segclk0 = 1'b0; segclk1 = 1'b0;
    value = 16'h0; blank = 4'h0; dp_in = 4'h0;
    load0 = 1'b0; load1 = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #0;
      chk("rst_an", 32'(an_x), 32'hF);
      chk("rst_seg", 32'(seg_x), 32'h7F);
      chk("rst_dp", 32'(dp_x), 32'd1);
      chk("rst_frame", 32'(frame_x), 32'd0);
    end
    clr = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    sel = 0;
    chk("idle_hold_an", 32'(an_x), 32'hF);

    // First frame of 1234, then a mid-frame load of ABCD while digit 1 is up.
    do_load(0, 16'h1234, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) do_step(0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    do_step(0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    do_step(0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    do_load(0, 16'hABCD, 4'h0, 4'h0);
    do_step(0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    chk("midload_old_d2", 32'(seg_x), 32'(7'b0100100));
    do_step(0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    do_step(0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    chk("midload_new_d0", 32'(seg_x), 32'(7'b0100001));

    // Load coinciding with the wrap.
    for (int i = 0; i < 3; i++) do_step(0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    do_step(0, 1'b1, 16'h5E6F, 4'h0, 4'h0, 1'b0);
    chk("wrapload_d0", 32'(seg_x), 32'(7'b0001110));
    chk("wrapload_pending", 32'(u0.pending), 32'd0);

    // Blank mask and decimal point on digit 2.
    do_load(0, 16'h9876, 4'b0100, 4'b0100);
    for (int i = 0; i < 5; i++) do_step(0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    do_step(0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    chk("blank_d2_an", 32'(an_x), 32'(4'b1011));
    chk("blank_d2_seg", 32'(seg_x), 32'h7F);
    chk("blank_d2_dp", 32'(dp_x), 32'd1);
    do_step(0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);

    // Random loads: mid-digit, in the step cycle, or none.
    for (int r = 0; r < 16; r++) begin
      mode = $urandom_range(0, 2);
      rv = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      rd = 4'($urandom);
      if (mode == 1) begin
        do_load(0, rv, rb, rd);
        do_step(0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
      end else if (mode == 2) begin
        do_step(0, 1'b1, rv, rb, rd, 1'b0);
      end else begin
        do_step(0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
      end
    end

    // Leading-zero suppression and a step arriving inside a long guard.
    do_load(1, 16'h0070, 4'h0, 4'h0);
    do_step(1, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    chk("lzs_d0", 32'(seg_x), 32'(7'b1000000));
    do_step(1, 1'b0, 16'h0, 4'h0, 4'h0, 1'b1);
    chk("dbl_idx_an", 32'(an_x), 32'(4'b1101));
    chk("lzs_d1", 32'(seg_x), 32'(7'b1111000));
    do_step(1, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    chk("lzs_d2_dark", 32'(seg_x), 32'h7F);
    do_step(1, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    chk("lzs_d3_an", 32'(an_x), 32'(4'b0111));
    chk("lzs_d3_dark", 32'(seg_x), 32'h7F);

    // Reset while u0 is in its guard and u1 is driving digit 3.
    sel = 0;
    @(posedge clk); #1;
    segclk0 = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    clr = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #0;
      chk("midrst_an", 32'(an_x), 32'hF);
      chk("midrst_seg", 32'(seg_x), 32'h7F);
      chk("midrst_dp", 32'(dp_x), 32'd1);
      chk("midrst_frame", 32'(frame_x), 32'd0);
    end
    segclk0 = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    sel = 0;
    chk("postrst_idle_an", 32'(an_x), 32'hF);
    do_step(0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    chk("postrst_d0_an", 32'(an_x), 32'(4'b1110));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
